// File: rtl/trap_request_arbiter.sv
// -----------------------------------------------------------------------------
// trap_request_arbiter
//
// Collects trap/exception requests from the EX and MEM pipeline stages,
// picks one by fixed priority, and latches it. It then presents a stable
// 3-bit trap_status code to the trap controller until that code's completion
// handshake finishes, and then releases it. Every sequence is bounded by a
// watchdog, and normal completions are counted.
//
// Trap status codes (shared with the trap controller):
//   0 NONE, 1 MISALIGNED_INSTR, 2 MISALIGNED_LOAD, 3 MISALIGNED_STORE,
//   4 ECALL, 5 EBREAK, 6 MRET, 7 FENCEI
//
// Ports
//   clk                   in   system clock
//   reset                 in   asynchronous active-low reset
//   clk_enable            in   state advances only when 1
//   mem_misaligned_load   in   MEM-stage misaligned load request
//   mem_misaligned_store  in   MEM-stage misaligned store request
//   ex_misaligned_instr   in   EX-stage misaligned branch/jump target request
//   ex_ecall              in   EX-stage ECALL
//   ex_ebreak             in   EX-stage EBREAK
//   ex_mret               in   EX-stage MRET
//   ex_fencei             in   EX-stage FENCE.I
//   trap_done             in   controller: 0 while pre-trap handling is busy
//   pth_done_flush        in   controller: flush phase active
//   debug_mode            in   controller debug-mode flag
//   trap_status           out  latched trap code (NONE when idle/releasing)
//   trap_busy             out  1 whenever the arbiter is not idle
//   trap_retire           out  one-cycle pulse on completion or timeout
//   trap_timeout          out  sticky watchdog-expiry flag
//   trap_count            out  saturating count of normal completions
// -----------------------------------------------------------------------------
module trap_request_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 8,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             mem_misaligned_load,
  input  logic             mem_misaligned_store,
  input  logic             ex_misaligned_instr,
  input  logic             ex_ecall,
  input  logic             ex_ebreak,
  input  logic             ex_mret,
  input  logic             ex_fencei,
  input  logic             trap_done,
  input  logic             pth_done_flush,
  input  logic             debug_mode,
  output logic [2:0]       trap_status,
  output logic             trap_busy,
  output logic             trap_retire,
  output logic             trap_timeout,
  output logic [CNT_W-1:0] trap_count
);

  localparam logic [2:0] TRAP_NONE             = 3'd0;
  localparam logic [2:0] TRAP_MISALIGNED_INSTR = 3'd1;
  localparam logic [2:0] TRAP_MISALIGNED_LOAD  = 3'd2;
  localparam logic [2:0] TRAP_MISALIGNED_STORE = 3'd3;
  localparam logic [2:0] TRAP_ECALL            = 3'd4;
  localparam logic [2:0] TRAP_EBREAK           = 3'd5;
  localparam logic [2:0] TRAP_MRET             = 3'd6;
  localparam logic [2:0] TRAP_FENCEI           = 3'd7;

  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] WD_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_code;
  logic [2:0]       r_status;
  logic             r_busy;
  logic             r_retire;
  logic             r_timeout;
  logic [CNT_W-1:0] r_count;
  logic [TMO_W-1:0] r_wd;
  logic             r_seen_busy;
  logic             r_flush_run;   // previous ACTIVE cycle had pth_done_flush=1

  logic [2:0]       w_winner;
  logic             w_req_valid;
  logic             w_complete;
  logic             w_wd_expire;

  // Fixed priority; MEM is older than EX so it always wins. In debug mode
  // only MRET and FENCE.I may be taken.
  always_comb begin
    w_winner = TRAP_NONE;
    if (!debug_mode && mem_misaligned_store)     w_winner = TRAP_MISALIGNED_STORE;
    else if (!debug_mode && mem_misaligned_load) w_winner = TRAP_MISALIGNED_LOAD;
    else if (!debug_mode && ex_misaligned_instr) w_winner = TRAP_MISALIGNED_INSTR;
    else if (!debug_mode && ex_ecall)            w_winner = TRAP_ECALL;
    else if (!debug_mode && ex_ebreak)           w_winner = TRAP_EBREAK;
    else if (ex_mret)                            w_winner = TRAP_MRET;
    else if (ex_fencei)                          w_winner = TRAP_FENCEI;
  end

  assign w_req_valid = (w_winner != TRAP_NONE);

  // Per-code completion handshake with the trap controller.
  always_comb begin
    w_complete = 1'b0;
    case (r_code)
      TRAP_FENCEI:                w_complete = 1'b1;
      TRAP_EBREAK, TRAP_MRET:     w_complete = trap_done && r_seen_busy;
      TRAP_ECALL,
      TRAP_MISALIGNED_INSTR,
      TRAP_MISALIGNED_LOAD,
      TRAP_MISALIGNED_STORE:      w_complete = pth_done_flush && r_flush_run;
      default:                    w_complete = 1'b0;
    endcase
  end

  assign w_wd_expire = (r_wd == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_code      <= TRAP_NONE;
      r_status    <= TRAP_NONE;
      r_busy      <= 1'b0;
      r_retire    <= 1'b0;
      r_timeout   <= 1'b0;
      r_count     <= '0;
      r_wd        <= '0;
      r_seen_busy <= 1'b0;
      r_flush_run <= 1'b0;
    end else if (clk_enable) begin
      r_retire <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_status <= TRAP_NONE;
          r_busy   <= 1'b0;
          if (w_req_valid) begin
            r_code      <= w_winner;
            r_status    <= w_winner;
            r_busy      <= 1'b1;
            r_wd        <= '0;
            r_seen_busy <= 1'b0;
            r_flush_run <= 1'b0;
            r_state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          r_wd        <= r_wd + WD_ONE;
          r_flush_run <= pth_done_flush;
          if (!trap_done) r_seen_busy <= 1'b1;
          // Completion wins over a watchdog expiry in the same cycle.
          if (w_complete) begin
            r_status <= TRAP_NONE;
            r_retire <= 1'b1;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_ONE;
            r_state  <= ST_RELEASE;
          end else if (w_wd_expire) begin
            r_status  <= TRAP_NONE;
            r_retire  <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // One dead cycle so a request still held from the retired trap
          // drains instead of being re-taken immediately.
          r_status <= TRAP_NONE;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_status <= TRAP_NONE;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign trap_status  = r_status;
  assign trap_busy    = r_busy;
  assign trap_retire  = r_retire;
  assign trap_timeout = r_timeout;
  assign trap_count   = r_count;

endmodule

// File: tb/tb_trap_request_arbiter.sv
module tb_trap_request_arbiter;

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_MINST = 3'd1;
  localparam logic [2:0] T_MLOAD = 3'd2;
  localparam logic [2:0] T_MSTOR = 3'd3;
  localparam logic [2:0] T_ECALL = 3'd4;
  localparam logic [2:0] T_EBRK  = 3'd5;
  localparam logic [2:0] T_MRET  = 3'd6;
  localparam logic [2:0] T_FENCE = 3'd7;

  logic        clk, reset, clk_enable;
  logic        mem_misaligned_load, mem_misaligned_store, ex_misaligned_instr;
  logic        ex_ecall, ex_ebreak, ex_mret, ex_fencei;
  logic        trap_done, pth_done_flush, debug_mode;
  logic [2:0]  trap_status;
  logic        trap_busy, trap_retire, trap_timeout;
  logic [15:0] trap_count;

  typedef struct {
    logic [2:0] code;
    int         hold;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  logic sticky_tmo = 1'b0;

  trap_request_arbiter #(.TIMEOUT_CYCLES(64), .TMO_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .mem_misaligned_load(mem_misaligned_load), .mem_misaligned_store(mem_misaligned_store),
    .ex_misaligned_instr(ex_misaligned_instr), .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak),
    .ex_mret(ex_mret), .ex_fencei(ex_fencei), .trap_done(trap_done),
    .pth_done_flush(pth_done_flush), .debug_mode(debug_mode),
    .trap_status(trap_status), .trap_busy(trap_busy), .trap_retire(trap_retire),
    .trap_timeout(trap_timeout), .trap_count(trap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs(input logic [6:0] v);
    {mem_misaligned_store, mem_misaligned_load, ex_misaligned_instr,
     ex_ecall, ex_ebreak, ex_mret, ex_fencei} = v;
  endtask

  task automatic push_exp(input logic [2:0] code, input int hold, input logic tmo);
    exp_t e;
    e.code = code; e.hold = hold; e.tmo = tmo;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: measures how long each latched code is presented and
  // checks it against the expectation queued when the request was driven.
  initial begin : monitor
    int         hold;
    logic [2:0] cur;
    logic       prev_ret;
    exp_t       e;
    hold = 0; cur = T_NONE; prev_ret = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold = 0; prev_ret = 1'b0;
      end else begin
        if (trap_status !== T_NONE) begin
          if (hold == 0) cur = trap_status;
          hold++;
        end
        if (trap_retire === 1'b1 && !prev_ret) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: retire seen code=%0d with nothing expected", cur);
          end else begin
            e = sb.pop_front();
            if (cur !== e.code) begin
              errors++;
              $display("FAIL sb_code: got %0d want %0d", cur, e.code);
            end
            checks++;
            if (hold != e.hold) begin
              errors++;
              $display("FAIL sb_hold: code %0d held %0d want %0d", e.code, hold, e.hold);
            end
            checks++;
            if (trap_timeout !== e.tmo) begin
              errors++;
              $display("FAIL sb_tmo: got %0b want %0b", trap_timeout, e.tmo);
            end
            $display("retire code=%0d hold=%0d tmo=%0b count=%0d", cur, hold, trap_timeout, trap_count);
          end
          hold = 0;
        end
        prev_ret = trap_retire;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; clk_enable = 1'b1; drive_reqs(7'h00);
    trap_done = 1'b1; pth_done_flush = 1'b0; debug_mode = 1'b0;
    repeat (3) tick();
    checks++;
    if ({trap_status, trap_busy, trap_retire, trap_timeout} !== 6'b0 || trap_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: status=%0d busy=%0b ret=%0b tmo=%0b cnt=%0d want all 0",
               trap_status, trap_busy, trap_retire, trap_timeout, trap_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fencei();
    ex_fencei = 1'b1;
    push_exp(T_FENCE, 1, sticky_tmo); exp_count++;
    tick();
    ex_fencei = 1'b0;
    checks++;
    if (trap_status !== T_FENCE || trap_busy !== 1'b1) begin
      errors++; $display("FAIL fencei_latch: status=%0d busy=%0b want 7/1", trap_status, trap_busy);
    end
    tick();
    checks++;
    if (trap_status !== T_NONE || trap_busy !== 1'b1 || trap_retire !== 1'b1 || trap_count !== 16'(exp_count)) begin
      errors++; $display("FAIL fencei_release: status=%0d busy=%0b ret=%0b cnt=%0d want 0/1/1/%0d",
                         trap_status, trap_busy, trap_retire, trap_count, exp_count);
    end
    tick();
    checks++;
    if (trap_busy !== 1'b0 || trap_retire !== 1'b0) begin
      errors++; $display("FAIL fencei_idle: busy=%0b ret=%0b want 0/0", trap_busy, trap_retire);
    end
  endtask

  task automatic test_load_flush();
    mem_misaligned_load = 1'b1; ex_ecall = 1'b1; trap_done = 1'b0; pth_done_flush = 1'b0;
    push_exp(T_MLOAD, 5, sticky_tmo); exp_count++;
    tick();
    drive_reqs(7'h00);
    checks++;
    if (trap_status !== T_MLOAD) begin
      errors++; $display("FAIL load_prio: got %0d want %0d", trap_status, T_MLOAD);
    end
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) pth_done_flush = 1'b1;
      tick();
      checks++;
      if (i < 4 && trap_status !== T_MLOAD) begin
        errors++; $display("FAIL load_hold: cycle %0d status=%0d want %0d", i, trap_status, T_MLOAD);
      end else if (i == 4 && (trap_retire !== 1'b1 || trap_status !== T_NONE || trap_count !== 16'(exp_count))) begin
        errors++; $display("FAIL load_retire: ret=%0b status=%0d cnt=%0d want 1/0/%0d",
                           trap_retire, trap_status, trap_count, exp_count);
      end
    end
    pth_done_flush = 1'b0; trap_done = 1'b1;
    tick();
  endtask

  function automatic logic [2:0] prio_code(input int k);
    case (k)
      0: prio_code = T_MSTOR;
      1: prio_code = T_MLOAD;
      2: prio_code = T_MINST;
      3: prio_code = T_ECALL;
      4: prio_code = T_EBRK;
      5: prio_code = T_MRET;
      default: prio_code = T_FENCE;
    endcase
  endfunction

  function automatic int model_hold(input logic [2:0] c);
    if (c == T_FENCE) model_hold = 1;
    else if (c == T_EBRK || c == T_MRET) model_hold = 2;
    else model_hold = 3;
  endfunction

  // Each request plus every lower-priority one; the highest must win.
  task automatic test_priority_sweep();
    logic [2:0] want;
    bit         idle;
    for (int k = 0; k < 7; k++) begin
      want = prio_code(k);
      drive_reqs(7'h7F >> k); trap_done = 1'b0; pth_done_flush = 1'b0;
      push_exp(want, model_hold(want), sticky_tmo); exp_count++;
      tick();
      drive_reqs(7'h00);
      checks++;
      if (trap_status !== want) begin
        errors++; $display("FAIL prio_%0d: got %0d want %0d", k, trap_status, want);
      end
      tick();
      trap_done = 1'b1; pth_done_flush = 1'b1;
      idle = 1'b0;
      for (int n = 0; n < 10 && !idle; n++) begin
        tick();
        if (trap_busy === 1'b0) idle = 1'b1;
      end
      checks++;
      if (!idle) begin
        errors++; $display("FAIL prio_done_%0d: busy=%0b want 0 within 10 cycles", k, trap_busy);
      end
      pth_done_flush = 1'b0;
    end
    checks++;
    if (trap_count !== 16'(exp_count)) begin
      errors++; $display("FAIL prio_count: got %0d want %0d", trap_count, exp_count);
    end
  endtask

  task automatic test_ebreak_debug();
    ex_ebreak = 1'b1; trap_done = 1'b0;
    push_exp(T_EBRK, 3, sticky_tmo); exp_count++;
    tick();
    ex_ebreak = 1'b0;
    tick(); tick();
    checks++;
    if (trap_status !== T_EBRK) begin
      errors++; $display("FAIL ebreak_hold: got %0d want %0d", trap_status, T_EBRK);
    end
    trap_done = 1'b1;
    tick();
    checks++;
    if (trap_retire !== 1'b1 || trap_status !== T_NONE) begin
      errors++; $display("FAIL ebreak_retire: ret=%0b status=%0d want 1/0", trap_retire, trap_status);
    end
    tick();
    debug_mode = 1'b1; ex_ecall = 1'b1;
    tick(); tick();
    checks++;
    if (trap_busy !== 1'b0 || trap_status !== T_NONE) begin
      errors++; $display("FAIL debug_ignore: busy=%0b status=%0d want 0/0", trap_busy, trap_status);
    end
    ex_ecall = 1'b0; mem_misaligned_store = 1'b1; ex_mret = 1'b1; trap_done = 1'b0;
    push_exp(T_MRET, 2, sticky_tmo); exp_count++;
    tick();
    drive_reqs(7'h00);
    checks++;
    if (trap_status !== T_MRET) begin
      errors++; $display("FAIL debug_mret: got %0d want %0d", trap_status, T_MRET);
    end
    tick();
    trap_done = 1'b1;
    tick();
    checks++;
    if (trap_retire !== 1'b1) begin
      errors++; $display("FAIL mret_retire: ret=%0b want 1", trap_retire);
    end
    tick();
    debug_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt_before;
    cnt_before = exp_count;
    ex_mret = 1'b1; trap_done = 1'b0;
    push_exp(T_MRET, 64, 1'b1);
    tick();
    ex_mret = 1'b0;
    repeat (63) tick();
    checks++;
    if (trap_status !== T_MRET || trap_timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_early: status=%0d tmo=%0b want 6/0", trap_status, trap_timeout);
    end
    tick();
    sticky_tmo = 1'b1;
    checks++;
    if (trap_retire !== 1'b1 || trap_timeout !== 1'b1 || trap_count !== 16'(cnt_before)) begin
      errors++; $display("FAIL tmo_expire: ret=%0b tmo=%0b cnt=%0d want 1/1/%0d",
                         trap_retire, trap_timeout, trap_count, cnt_before);
    end
    trap_done = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    ex_ecall = 1'b1; trap_done = 1'b1; pth_done_flush = 1'b1;
    push_exp(T_ECALL, 2, sticky_tmo); exp_count++;
    tick();
    tick(); tick();
    checks++;
    if (trap_retire !== 1'b1 || trap_status !== T_NONE) begin
      errors++; $display("FAIL b2b_retire: ret=%0b status=%0d want 1/0", trap_retire, trap_status);
    end
    tick();
    checks++;
    if (trap_busy !== 1'b0 || trap_status !== T_NONE) begin
      errors++; $display("FAIL b2b_release_ignore: busy=%0b status=%0d want 0/0", trap_busy, trap_status);
    end
    tick();
    checks++;
    if (trap_status !== T_ECALL || trap_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_relatch: status=%0d busy=%0b want 4/1", trap_status, trap_busy);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({trap_status, trap_busy, trap_retire, trap_timeout} !== 6'b0 || trap_count !== 16'd0) begin
      errors++; $display("FAIL async_reset: status=%0d busy=%0b ret=%0b tmo=%0b cnt=%0d want all 0",
                         trap_status, trap_busy, trap_retire, trap_timeout, trap_count);
    end
    drive_reqs(7'h00); pth_done_flush = 1'b0;
    sticky_tmo = 1'b0; exp_count = 0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_clk_enable();
    // Flush run must survive a freeze: 1 flush cycle, freeze, 1 flush cycle.
    ex_ecall = 1'b1; pth_done_flush = 1'b1; trap_done = 1'b1;
    push_exp(T_ECALL, 12, sticky_tmo); exp_count++;
    tick();
    ex_ecall = 1'b0;
    tick();
    clk_enable = 1'b0; pth_done_flush = 1'b0;
    repeat (10) tick();
    checks++;
    if (trap_status !== T_ECALL || trap_busy !== 1'b1) begin
      errors++; $display("FAIL freeze_hold: status=%0d busy=%0b want 4/1", trap_status, trap_busy);
    end
    clk_enable = 1'b1; pth_done_flush = 1'b1;
    tick();
    checks++;
    if (trap_retire !== 1'b1 || trap_count !== 16'(exp_count)) begin
      errors++; $display("FAIL freeze_flush_done: ret=%0b cnt=%0d want 1/%0d", trap_retire, trap_count, exp_count);
    end
    pth_done_flush = 1'b0;
    tick();
    // Watchdog freeze: 5 enabled, 10 frozen, then 59 more enabled cycles.
    ex_mret = 1'b1; trap_done = 1'b0;
    push_exp(T_MRET, 74, 1'b1);
    tick();
    ex_mret = 1'b0;
    repeat (5) tick();
    clk_enable = 1'b0;
    repeat (10) tick();
    clk_enable = 1'b1;
    repeat (58) tick();
    checks++;
    if (trap_status !== T_MRET || trap_timeout !== 1'b0) begin
      errors++; $display("FAIL freeze_wd_early: status=%0d tmo=%0b want 6/0", trap_status, trap_timeout);
    end
    tick();
    sticky_tmo = 1'b1;
    checks++;
    if (trap_retire !== 1'b1 || trap_timeout !== 1'b1) begin
      errors++; $display("FAIL freeze_wd_expire: ret=%0b tmo=%0b want 1/1", trap_retire, trap_timeout);
    end
    clk_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (trap_retire !== 1'b1) begin
      errors++; $display("FAIL retire_frozen: ret=%0b want 1", trap_retire);
    end
    clk_enable = 1'b1; trap_done = 1'b1;
    tick();
    checks++;
    if (trap_retire !== 1'b0 || trap_busy !== 1'b0 || trap_count !== 16'(exp_count)) begin
      errors++; $display("FAIL retire_drop: ret=%0b busy=%0b cnt=%0d want 0/0/%0d",
                         trap_retire, trap_busy, trap_count, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_fencei();
    test_load_flush();
    test_priority_sweep();
    test_ebreak_debug();
    test_timeout();
    test_back_to_back();
    test_clk_enable();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected retires never seen", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
